// File: rtl/data_sram_responder.sv
// Responder for the core's data SRAM port: byte-enabled synchronous RAM with a
// fully pipelined read return of READ_LAT cycles, a read-valid strobe and an error pulse.
module data_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        data_sram_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $fatal(1, "data_sram_responder: READ_LAT must be in 1..4");
    end
    if (DEPTH_WORDS < 16 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $fatal(1, "data_sram_responder: DEPTH_WORDS must be a power of two >= 16");
    end

    // Handshake: no ready; every cycle with en high (reset low) is accepted, and
    // results come back exactly READ_LAT cycles later flagged by rvalid and/or err.
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          in_window;
    logic          accept;
    logic          is_write;
    logic          unused_addr_bits;

    assign offset           = data_sram_addr - BASE_ADDR;
    assign index            = offset[AW+1:2];
    assign in_window        = {1'b0, offset} < WIN_BYTES;
    assign accept           = data_sram_en && !reset;
    assign is_write         = data_sram_we != 4'b0000;
    assign unused_addr_bits = ^{offset[1:0], offset[31:AW+2]};

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (accept && is_write && in_window) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_we[b]) begin
                    mem[index][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage i holds a request i+1 edges after acceptance; the last stage drives the outputs.
    logic [READ_LAT-1:0] p_vld, p_rd, p_err;
    logic [31:0]         p_data [READ_LAT];
    logic [READ_LAT-1:0] in_vld, in_rd, in_err;
    logic [31:0]         in_data [READ_LAT];

    always_comb begin
        in_vld[0]  = accept;
        in_rd[0]   = !is_write;
        in_err[0]  = !in_window;
        in_data[0] = in_window ? mem[index] : 32'h0;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            in_vld[i]  = p_vld[i-1];
            in_rd[i]   = p_rd[i-1];
            in_err[i]  = p_err[i-1];
            in_data[i] = p_data[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_vld <= '0;
            p_rd  <= '0;
            p_err <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                p_data[i] <= 32'h0;
            end
        end else begin
            p_vld <= in_vld;
            p_rd  <= in_rd;
            p_err <= in_err;
            for (int i = 0; i < int'(READ_LAT) - 1; i++) begin
                p_data[i] <= in_data[i];
            end
            // The output stage only reloads on a completing read so rdata holds otherwise.
            if (in_vld[READ_LAT-1] && in_rd[READ_LAT-1]) begin
                p_data[READ_LAT-1] <= in_data[READ_LAT-1];
            end
        end
    end

    assign data_sram_rdata  = p_data[READ_LAT-1];
    assign data_sram_rvalid = p_vld[READ_LAT-1] && p_rd[READ_LAT-1];
    assign data_sram_err    = p_vld[READ_LAT-1] && p_err[READ_LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one instance at READ_LAT=1, one at READ_LAT=3.
module tb_data_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rst1 = 1'b0, en1 = 1'b0;
    logic [3:0]  we1 = '0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        rvalid1, err1;

    logic        rst3 = 1'b0, en3 = 1'b0;
    logic [3:0]  we3 = '0;
    logic [31:0] addr3 = '0, wdata3 = '0, rdata3;
    logic        rvalid3, err3;

    data_sram_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(rst1), .data_sram_en(en1), .data_sram_we(we1),
        .data_sram_addr(addr1), .data_sram_wdata(wdata1), .data_sram_rdata(rdata1),
        .data_sram_rvalid(rvalid1), .data_sram_err(err1)
    );

    data_sram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .READ_LAT(3)) u_lat3 (
        .clk(clk), .reset(rst3), .data_sram_en(en3), .data_sram_we(we3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .data_sram_rvalid(rvalid3), .data_sram_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        en1 = en; we1 = we; addr1 = a; wdata1 = d;
        step();
    endtask

    task automatic drv3(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        en3 = en; we3 = we; addr3 = a; wdata3 = d;
        step();
    endtask

    task automatic out1(input string tag, input logic [31:0] rd, input logic rv, input logic er);
        chk({tag, ".rdata"}, rdata1, rd);
        chk({tag, ".rvalid"}, 32'(rvalid1), 32'(rv));
        chk({tag, ".err"}, 32'(err1), 32'(er));
    endtask

    task automatic out3(input string tag, input logic [31:0] rd, input logic rv, input logic er);
        chk({tag, ".rdata"}, rdata3, rd);
        chk({tag, ".rvalid"}, 32'(rvalid3), 32'(rv));
        chk({tag, ".err"}, 32'(err3), 32'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset both instances before any clock edge.
        rst1 = 1'b1;
        rst3 = 1'b1;
        #2;
        out1("reset1", 32'h0, 1'b0, 1'b0);
        out3("reset3", 32'h0, 1'b0, 1'b0);
        step();
        rst1 = 1'b0;
        rst3 = 1'b0;

        // READ_LAT=1 instance
        drv1(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        out1("wr40", 32'h0, 1'b0, 1'b0);
        drv1(1'b1, 4'h0, 32'h40, 32'h0);
        out1("rd40", 32'hDEAD_BEEF, 1'b1, 1'b0);
        drv1(1'b0, 4'h0, 32'h0, 32'h0);
        out1("idle_hold", 32'hDEAD_BEEF, 1'b0, 1'b0);
        drv1(1'b1, 4'b0101, 32'h40, 32'h1122_3344);
        out1("wr_merge", 32'hDEAD_BEEF, 1'b0, 1'b0);
        drv1(1'b1, 4'h0, 32'h40, 32'h0);
        out1("rd_merge", 32'hDE22_BE44, 1'b1, 1'b0);
        drv1(1'b1, 4'h0, 32'h43, 32'h0);
        out1("rd_lowbits", 32'hDE22_BE44, 1'b1, 1'b0);
        drv1(1'b1, 4'hF, 32'h0, 32'hA5A5_0000);
        out1("wr0", 32'hDE22_BE44, 1'b0, 1'b0);
        drv1(1'b1, 4'h0, 32'h4000, 32'h0);
        out1("rd_oow", 32'h0, 1'b1, 1'b1);
        drv1(1'b1, 4'hF, 32'h4000, 32'hFFFF_FFFF);
        out1("wr_oow", 32'h0, 1'b0, 1'b1);
        drv1(1'b1, 4'hF, 32'hFFFF_FFFC, 32'h1234_5678);
        out1("wr_wrap", 32'h0, 1'b0, 1'b1);
        drv1(1'b1, 4'h0, 32'h0, 32'h0);
        out1("rd0_after_oow", 32'hA5A5_0000, 1'b1, 1'b0);
        drv1(1'b1, 4'h0, 32'h3FFC, 32'h0);
        out1("rd_last_word", 32'h0, 1'b1, 1'b0);
        drv1(1'b0, 4'h0, 32'h0, 32'h0);
        out1("idle_end", 32'h0, 1'b0, 1'b0);

        // READ_LAT=3 instance: preload, then three back-to-back reads
        drv3(1'b1, 4'hF, 32'h0, 32'd1);
        drv3(1'b1, 4'hF, 32'h4, 32'd2);
        drv3(1'b1, 4'hF, 32'h8, 32'd3);
        out3("lat3_pre", 32'h0, 1'b0, 1'b0);
        drv3(1'b1, 4'h0, 32'h0, 32'h0);
        out3("lat3_c1", 32'h0, 1'b0, 1'b0);
        drv3(1'b1, 4'h0, 32'h4, 32'h0);
        out3("lat3_c2", 32'h0, 1'b0, 1'b0);
        drv3(1'b1, 4'h0, 32'h8, 32'h0);
        out3("lat3_c3", 32'd1, 1'b1, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("lat3_c4", 32'd2, 1'b1, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("lat3_c5", 32'd3, 1'b1, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("lat3_hold", 32'd3, 1'b0, 1'b0);

        // Out-of-window write: err appears exactly three cycles after acceptance
        drv3(1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
        out3("oww_c1", 32'd3, 1'b0, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("oww_c2", 32'd3, 1'b0, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("oww_c3", 32'd3, 1'b0, 1'b1);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("oww_c4", 32'd3, 1'b0, 1'b0);

        // Two reads in flight, then an asynchronous reset mid-cycle
        drv3(1'b1, 4'h0, 32'h0, 32'h0);
        drv3(1'b1, 4'h0, 32'h4, 32'h0);
        en3 = 1'b0;
        we3 = 4'h0;
        rst3 = 1'b1;
        #2;
        out3("midreset", 32'h0, 1'b0, 1'b0);
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            out3($sformatf("post_reset_%0d", i), 32'h0, 1'b0, 1'b0);
        end
        drv3(1'b1, 4'h0, 32'h8, 32'h0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("ram_kept_c2", 32'h0, 1'b0, 1'b0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("ram_kept_c3", 32'd3, 1'b1, 1'b0);
        drv3(1'b1, 4'h0, 32'h0, 32'h0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        out3("word0_kept", 32'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder end of the core's data SRAM port. Answers the en/we/addr/wdata requests driven by the execute/memory stages and returns data_sram_rdata.
- Single-port, word-wide synchronous RAM model with byte write enables and a parameterised, fully pipelined read latency.
- Adds a read-valid strobe and an error pulse for out-of-window accesses.
- Used as the data memory behind the pipeline in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, at least 16.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- READ_LAT, 1: cycles from request acceptance to data; legal range 1..4.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high.
- data_sram_en, input, 1: request strobe; one request per cycle while high.
- data_sram_we, input, 4: byte write enables, bit i writes wdata[8i+7:8i]. Nonzero means write; zero means read.
- data_sram_addr, input, 32: byte address; bits [1:0] are ignored.
- data_sram_wdata, input, 32: write data.
- data_sram_rdata, output, 32: read data.
- data_sram_rvalid, output, 1: one-cycle pulse when rdata carries a newly returned read.
- data_sram_err, output, 1: one-cycle pulse, READ_LAT cycles after an out-of-window request.

Behaviour:
- Reset asserted (async):
  - rdata=0, rvalid=0, err=0.
  - All read-pipeline stage valids are cleared; in-flight reads are discarded and never produce rvalid.
  - RAM contents are not cleared.
- Request acceptance:
  - Every cycle with en=1 and reset low is accepted. There is no stall or back-pressure, so throughput is one request per cycle.
  - en=0 means an idle cycle with no state change except the pipeline advancing.
- Address decode:
  - in_window = (addr - BASE_ADDR) < DEPTH_WORDS*4, computed in 32-bit unsigned arithmetic.
  - index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Write (en=1, we!=0):
  - At that clock edge, each enabled byte of RAM[index] takes the matching wdata byte. Disabled bytes keep their value.
  - Out-of-window writes change nothing.
  - Writes never set rvalid.
- Read (en=1, we=0):
  - RAM[index] is sampled at the acceptance edge, into pipeline stage 1.
  - The result advances one stage per cycle. On the edge that completes stage READ_LAT, rdata is loaded and rvalid=1 for one cycle.
  - With READ_LAT=1, a request issued in cycle N has rdata valid in cycle N+1, which is the memory-stage cycle.
  - An out-of-window read returns rdata=0 with rvalid=1 and err=1 in the same cycle.
- Error on writes: an out-of-window write raises err=1 READ_LAT cycles after acceptance, with rvalid=0. err travels in the same pipeline as reads.
- Read-after-write:
  - A write in cycle N followed by a read of the same word in cycle N+1 returns the new data.
  - Reads are not forwarded from a same-cycle write; a single request cannot be both.
- rdata hold: rdata holds its last returned value until the next read completes. Writes and idle cycles do not disturb it.
- Back-to-back reads: READ_LAT reads can be in flight at once. Each completes on consecutive cycles in issue order, with rvalid held high across them.
- Address wrap: addresses wrap inside the 32-bit subtraction only. No aliasing inside the window; everything outside is an error.
- Reset released: the first request is accepted on the first rising edge after reset deasserts.
- Illegal READ_LAT: values outside 1..4 stop elaboration with a fatal error.

Test Plan:
- Reset with READ_LAT=1 -> rdata=0, rvalid=0 and err=0 immediately, with no clock edge required.
- Write word 0x40 with we=4'hF, wdata=32'hDEADBEEF, then read 0x40 next cycle -> one cycle later rdata=32'hDEADBEEF, rvalid=1, err=0.
- Byte-enable merge: starting from 32'hDEADBEEF, write we=4'b0101, wdata=32'h11223344 to 0x40, then read -> rdata=32'hDE22BE44.
- READ_LAT=3: reads of 0x0, 0x4, 0x8 on cycles 0, 1, 2, preloaded with 1, 2, 3 -> rvalid high on cycles 3, 4, 5 with rdata 1, 2, 3. rdata then holds 3 with rvalid=0.
- Out-of-window read at BASE_ADDR+DEPTH_WORDS*4 -> next cycle rdata=0, rvalid=1, err=1.
- Out-of-window write leaves RAM unchanged; read-back of word 0 is unchanged.
- Reset pulsed with 2 reads in flight (READ_LAT=3) -> no rvalid after release. A later read of a written word returns the pre-reset data, since RAM is not cleared.
